// File: rtl/csr_file.sv
// Machine-mode CSR file: trap CSRs, interrupt sampling, and trap/mret PC redirect.
// Outputs are combinational from registered state and the memory-stage controls.
module csr_file #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            csr_reg_rd,
  input  logic            csr_reg_wr,
  input  logic            is_mret,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic [XLEN-1:0] csr_rdata,
  output logic            epc_taken,
  output logic [XLEN-1:0] epc_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic            mstatus_mie_r, mstatus_mpie_r;
  logic            mie_meie_r, mie_mtie_r;
  logic            mip_meip_r, mip_mtip_r;
  logic [XLEN-1:0] mtvec_r, mepc_r, mcause_r;

  logic            ext_pend_s, tmr_pend_s, irq_s, trap_s, mret_s, wr_en_s;
  logic [3:0]      cause_s;
  logic [XLEN-1:0] trap_base_s, trap_tgt_s, rd_mux_s;

  assign ext_pend_s  = mip_meip_r & mie_meie_r;
  assign tmr_pend_s  = mip_mtip_r & mie_mtie_r;
  assign irq_s       = mstatus_mie_r & instr_valid & (ext_pend_s | tmr_pend_s);
  assign trap_s      = irq_s & ~is_mret;
  assign mret_s      = is_mret & instr_valid;
  assign wr_en_s     = csr_reg_wr & instr_valid & ~trap_s;
  assign cause_s     = ext_pend_s ? 4'd11 : 4'd7;
  assign trap_base_s = {mtvec_r[XLEN-1:2], 2'b00};
  // Vectored mode only for mode 01; mode 1x falls back to direct.
  assign trap_tgt_s  = (mtvec_r[1:0] == 2'b01)
                       ? trap_base_s + {{(XLEN-6){1'b0}}, cause_s, 2'b00}
                       : trap_base_s;

  // Read mux: pre-write CSR value, unimplemented addresses read zero.
  always_comb begin
    rd_mux_s = '0;
    case (csr_addr)
      ADDR_MSTATUS: rd_mux_s = {{(XLEN-8){1'b0}}, mstatus_mpie_r, 3'b000, mstatus_mie_r, 3'b000};
      ADDR_MIE:     rd_mux_s = {{(XLEN-12){1'b0}}, mie_meie_r, 3'b000, mie_mtie_r, 7'b0000000};
      ADDR_MTVEC:   rd_mux_s = mtvec_r;
      ADDR_MEPC:    rd_mux_s = mepc_r;
      ADDR_MCAUSE:  rd_mux_s = mcause_r;
      ADDR_MIP:     rd_mux_s = {{(XLEN-12){1'b0}}, mip_meip_r, 3'b000, mip_mtip_r, 7'b0000000};
      default:      rd_mux_s = '0;
    endcase
  end

  // Output drive: reset forces all outputs quiet.
  always_comb begin
    csr_rdata = '0;
    epc_taken = 1'b0;
    epc_pc    = '0;
    if (rst) begin
      csr_rdata = '0;
    end else begin
      csr_rdata = csr_reg_rd ? rd_mux_s : '0;
      epc_taken = trap_s | mret_s;
      if (trap_s) begin
        epc_pc = trap_tgt_s;
      end else if (mret_s) begin
        epc_pc = mepc_r;
      end else begin
        epc_pc = '0;
      end
    end
  end

  // CSR state: interrupt sampling, software writes, trap entry and mret.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_meie_r     <= 1'b0;
      mie_mtie_r     <= 1'b0;
      mip_meip_r     <= 1'b0;
      mip_mtip_r     <= 1'b0;
      mtvec_r        <= '0;
      mepc_r         <= '0;
      mcause_r       <= '0;
    end else begin
      mip_meip_r <= ext_irq;
      mip_mtip_r <= timer_irq;
      if (wr_en_s) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mstatus_mie_r  <= csr_wdata[3];
            mstatus_mpie_r <= csr_wdata[7];
          end
          ADDR_MIE: begin
            mie_meie_r <= csr_wdata[11];
            mie_mtie_r <= csr_wdata[7];
          end
          ADDR_MTVEC:  mtvec_r  <= csr_wdata;
          ADDR_MEPC:   mepc_r   <= {csr_wdata[XLEN-1:2], 2'b00};
          ADDR_MCAUSE: mcause_r <= csr_wdata;
          default:     ;
        endcase
      end
      // Trap/mret update mstatus after any write so they take precedence.
      if (trap_s) begin
        mepc_r         <= pc;
        mcause_r       <= {1'b1, {(XLEN-5){1'b0}}, cause_s};
        mstatus_mpie_r <= mstatus_mie_r;
        mstatus_mie_r  <= 1'b0;
      end else if (mret_s) begin
        mstatus_mie_r  <= mstatus_mpie_r;
        mstatus_mpie_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: a word-level CSR model predicts each cycle's
// outputs, which a negedge monitor compares against the DUT.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [11:0] csr_addr = 12'd0;
  logic [31:0] csr_wdata = 32'd0;
  logic        csr_reg_rd = 1'b0;
  logic        csr_reg_wr = 1'b0;
  logic        is_mret = 1'b0;
  logic        ext_irq = 1'b0;
  logic        timer_irq = 1'b0;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_pc;

  csr_file #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_reg_rd(csr_reg_rd),
    .csr_reg_wr(csr_reg_wr), .is_mret(is_mret), .ext_irq(ext_irq),
    .timer_irq(timer_irq), .csr_rdata(csr_rdata), .epc_taken(epc_taken),
    .epc_pc(epc_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        taken;
    logic [31:0] tpc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: architectural CSRs as whole 32-bit words.
  logic [31:0] m_mstatus = 32'd0, m_mie = 32'd0, m_mtvec = 32'd0;
  logic [31:0] m_mepc = 32'd0, m_mcause = 32'd0, m_mip = 32'd0;
  logic        ei = 1'b0, ti = 1'b0;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic r, input logic iv, input logic [31:0] p,
                      input logic [11:0] a, input logic [31:0] wd,
                      input logic rd, input logic wr, input logic mr,
                      input logic e, input logic t);
    exp_t x;
    logic pend_e, pend_t, trap, mret_eff;
    logic [31:0] cause, tgt;
    @(posedge clk);
    #1;
    rst = r; instr_valid = iv; pc = p; csr_addr = a; csr_wdata = wd;
    csr_reg_rd = rd; csr_reg_wr = wr; is_mret = mr; ext_irq = e; timer_irq = t;
    if (r) begin
      x.rdata = 32'd0; x.taken = 1'b0; x.tpc = 32'd0;
      m_mstatus = 32'd0; m_mie = 32'd0; m_mtvec = 32'd0;
      m_mepc = 32'd0; m_mcause = 32'd0; m_mip = 32'd0;
    end else begin
      pend_e   = m_mip[11] && m_mie[11];
      pend_t   = m_mip[7] && m_mie[7];
      trap     = m_mstatus[3] && iv && (pend_e || pend_t) && !mr;
      mret_eff = mr && iv;
      cause    = pend_e ? 32'd11 : 32'd7;
      tgt      = (m_mtvec & ~32'd3) + (((m_mtvec & 32'd3) == 32'd1) ? 32'd4 * cause : 32'd0);
      x.rdata  = rd ? m_read(a) : 32'd0;
      x.taken  = trap || mret_eff;
      x.tpc    = trap ? tgt : (mret_eff ? m_mepc : 32'd0);
      if (wr && iv && !trap) begin
        case (a)
          12'h300: m_mstatus = wd & 32'h0000_0088;
          12'h304: m_mie     = wd & 32'h0000_0880;
          12'h305: m_mtvec   = wd;
          12'h341: m_mepc    = wd & ~32'd3;
          12'h342: m_mcause  = wd;
          default: ;
        endcase
      end
      if (trap) begin
        m_mepc    = p;
        m_mcause  = 32'h8000_0000 | cause;
        m_mstatus = m_mstatus[3] ? 32'h0000_0080 : 32'h0000_0000;
      end else if (mret_eff) begin
        m_mstatus = 32'h0000_0080 | (m_mstatus[7] ? 32'h0000_0008 : 32'h0000_0000);
      end
      m_mip = (e ? 32'h0000_0800 : 32'd0) | (t ? 32'h0000_0080 : 32'd0);
    end
    exp_q.push_back(x);
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 32'h0000_1000, a, d, 1'b0, 1'b1, 1'b0, ei, ti);
  endtask

  task automatic rd_csr(input logic [11:0] a);
    step(1'b0, 1'b1, 32'h0000_1004, a, 32'd0, 1'b1, 1'b0, 1'b0, ei, ti);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest predicted response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("csr_rdata", csr_rdata, e.rdata);
      check("epc_taken", {31'd0, epc_taken}, {31'd0, e.taken});
      check("epc_pc", epc_pc, e.tpc);
    end
  end

  initial begin
    logic [11:0] addr_tab [8];
    logic [31:0] wd_tab [6];
    logic [31:0] tmp;
    logic [11:0] a;
    logic [31:0] wd;
    logic        mr, wr;
    int          wait_cnt;
    addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h000};
    wd_tab   = '{32'hFFFF_FFFF, 32'h0000_0008, 32'h0000_0088, 32'h0000_0880, 32'h0000_0101, 32'h0000_0080};

    // Reset and readback of every implemented address plus an unimplemented one.
    step(1'b1, 1'b0, 32'd0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) rd_csr(addr_tab[i]);

    // Masked writes.
    wr_csr(12'h300, 32'hFFFF_FFFF); rd_csr(12'h300);
    wr_csr(12'h344, 32'hFFFF_FFFF); rd_csr(12'h344);
    wr_csr(12'h341, 32'h0000_0103); rd_csr(12'h341);
    wr_csr(12'h300, 32'h0000_0000);

    // Direct-mode timer trap.
    wr_csr(12'h305, 32'h0000_0080);
    wr_csr(12'h304, 32'h0000_0080);
    wr_csr(12'h300, 32'h0000_0008);
    ti = 1'b1;
    step(1'b0, 1'b1, 32'h0000_0200, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, ei, ti);
    step(1'b0, 1'b1, 32'h0000_0200, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, ei, ti);
    rd_csr(12'h341); rd_csr(12'h342); rd_csr(12'h300);
    ti = 1'b0;

    // Vectored mode with external beating timer.
    wr_csr(12'h305, 32'h0000_0101);
    wr_csr(12'h304, 32'h0000_0880);
    wr_csr(12'h300, 32'h0000_0008);
    ei = 1'b1; ti = 1'b1;
    step(1'b0, 1'b1, 32'h0000_0300, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, ei, ti);
    step(1'b0, 1'b1, 32'h0000_0304, 12'h000, 32'd0, 1'b0, 1'b0, 1'b0, ei, ti);
    rd_csr(12'h342);

    // mret wins over the still-pending interrupt, then re-entry; then bubbles.
    wr_csr(12'h300, 32'h0000_0088);
    step(1'b0, 1'b1, 32'h0000_0400, 12'h000, 32'd0, 1'b0, 1'b0, 1'b1, ei, ti);
    rd_csr(12'h300);
    step(1'b0, 1'b1, 32'h0000_0404, 12'h000, 32'd0, 1'b0, 1'b0, 1'b1, ei, ti);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 32'h0000_0408, 12'h305, 32'h0000_0040, 1'b1, 1'b1, 1'b1, ei, ti);
    step(1'b0, 1'b1, 32'h0000_040C, 12'h305, 32'h0000_0040, 1'b0, 1'b1, 1'b0, ei, ti);
    rd_csr(12'h305); rd_csr(12'h341); rd_csr(12'h300);

    // Reset while an interrupt is pending and enabled.
    wr_csr(12'h300, 32'h0000_0008);
    step(1'b1, 1'b1, 32'h0000_0500, 12'h300, 32'd0, 1'b1, 1'b0, 1'b0, ei, ti);
    rd_csr(12'h300);
    ei = 1'b0; ti = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      a   = addr_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) begin
        tmp = $urandom;
        a = tmp[11:0];
      end
      wd  = ($urandom_range(0, 1) == 0) ? wd_tab[$urandom_range(0, 5)] : 32'($urandom);
      mr  = ($urandom_range(0, 9) == 0);
      wr  = !mr && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) ei = ~ei;
      if ($urandom_range(0, 7) == 0) ti = ~ti;
      tmp = $urandom;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0), tmp & ~32'd3,
           a, wd, 1'($urandom_range(0, 1)), wr, mr, ei, ti);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
